cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// - Shares the single block-wide main-memory port between the instruction cache (I) and data cache (D) miss/writeback engines.
// - Round-robin grant, one transaction in flight, grant held until completion.
// - Sits between both caches and the memory controller; each cache sees a private memory interface (read/addr/busy/data).
// PARAMETERS
// - BLOCK_SIZE  32  cache line size in bytes; data buses are BLOCK_SIZE*8 bits
// - ADDR_WIDTH  32  byte address width
// PORTS
// - clk            in   1      single clock, all state updates on posedge
// - rst            in   1      synchronous, active-high reset
// - iMemRead       in   1      I-side read request (level, held until iMemBusy low)
// - iMemAddress    in   ADDR   I-side line address
// - iMemBusy       out  1      I-side busy; low = transaction complete / idle
// - iMemReadData   out  BS*8   I-side line data, valid when iMemBusy falls during grant
// - dMemRead       in   1      D-side read request (level)
// - dMemWrite      in   1      D-side write-back request (level; never asserted together with dMemRead)
// - dMemAddress    in   ADDR   D-side line address
// - dMemWriteData  in   BS*8   D-side write-back line
// - dMemBusy       out  1      D-side busy
// - dMemReadData   out  BS*8   D-side line data
// - memRead        out  1      to memory: read command
// - memWrite       out  1      to memory: write command
// - memAddress     out  ADDR   to memory: latched address
// - memWriteData   out  BS*8   to memory: latched write line
// - memBusy        in   1      from memory: high from the cycle after a command until data ready
// - memReadData    in   BS*8   from memory: valid in the cycle memBusy is sampled low in WAIT
// BEHAVIOUR
// - States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE (2-bit encoding).
// - IDLE: if eligible request(s) present, pick winner and latch grant, command, address and write data; go to ISSUE. Otherwise stay.
// - Arbitration: only one requester -> it wins. Both requesting -> the one not granted last wins (lastGrant bit). lastGrant resets to I, so D wins the first tie.
// - ISSUE: drive memRead/memWrite = latched command, memAddress/memWriteData = latched values. Always go to WAIT.
// - WAIT: hold command and address; memBusy high -> stay; memBusy low -> capture memReadData into respData, go to DONE.
// - DONE: memRead = memWrite = 0. Granted side's busy is low for exactly this cycle with respData on its ReadData. lastGrant <= grant; go to IDLE.
// - Requester busy: xMemBusy = xReq && !(state==DONE && grant==x). A requester that is waiting for grant, or whose command is still in flight, sees busy high.
// - Cooldown: in the IDLE cycle right after DONE, the previously granted side's request is ignored; a requester may drop its request one cycle late without a duplicate transaction.
// - Latency per transaction: 3 cycles + memBusy-high cycles, measured from the IDLE accept edge to the end of DONE.
// - Outputs outside ISSUE/WAIT: memRead = memWrite = 0, memAddress = 0, memWriteData = 0. ReadData outputs always show respData.
// - Requests that change or drop while granted (ISSUE/WAIT) are ignored; the latched transaction completes.
// - Reset (any state, including mid-WAIT): state = IDLE, grant = I, lastGrant = I, cooldown = 0, respData = 0, latched regs = 0. The memory controller is reset by the same rst.
// - No timeout: a stuck memBusy holds the arbiter in WAIT indefinitely.
// STRUCTURE
// - Shared package: state encodings (IDLE/ISSUE/WAIT/DONE), GRANT_I = 0 / GRANT_D = 1, and the command encoding (CMD_READ, CMD_WRITE).
// - Single module: round-robin select is a few gates, so no sub-module is needed. Registers: state, grant, lastGrant, cooldown, cmd, addr, wdata, respData.
// TESTING
// - I-only read at 0x0000_1040, memBusy high 4 cycles, memReadData = pattern A -> memRead high 5 cycles (ISSUE + WAIT), iMemBusy low 1 cycle with pattern A, dMemBusy = 0.
// - I and D read requested in the same cycle after reset -> D granted first. iMemBusy stays high until D completes, then I is issued, with no idle gap beyond the cooldown rule.
// - D write at 0x0000_2000 with data = pattern B -> memWrite = 1, memWriteData = B, memRead = 0 throughout; dMemBusy low for exactly 1 cycle.
// - D holds its request 1 cycle past DONE while I also requests -> I granted next. No duplicate D transaction; exactly one D command counted.
// - Continuous I and D requests for 10 transactions -> grants strictly alternate D, I, D, I...
// - rst asserted during WAIT -> next cycle memRead = 0, both busy outputs equal their req inputs, state IDLE. After rst drops, a pending request is re-issued from ISSUE.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings for the I/D cache main-memory arbiter: FSM states,
// grant owners, memory command codes and the round-robin pick.
package cache_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // On a tie the side that did not own the previous transaction wins.
    function automatic logic pick_grant(input logic i_elig, input logic d_elig,
                                        input logic last_grant);
        logic win;
        if (i_elig && d_elig)
            win = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        else if (d_elig)
            win = GRANT_D;
        else
            win = GRANT_I;
        return win;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and
// D-cache miss/writeback engines; one transaction in flight at a time.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iMemRead,
    input  logic [ADDR_WIDTH-1:0]   iMemAddress,
    output logic                    iMemBusy,
    output logic [BLOCK_SIZE*8-1:0] iMemReadData,
    input  logic                    dMemRead,
    input  logic                    dMemWrite,
    input  logic [ADDR_WIDTH-1:0]   dMemAddress,
    input  logic [BLOCK_SIZE*8-1:0] dMemWriteData,
    output logic                    dMemBusy,
    output logic [BLOCK_SIZE*8-1:0] dMemReadData,
    output logic                    memRead,
    output logic                    memWrite,
    output logic [ADDR_WIDTH-1:0]   memAddress,
    output logic [BLOCK_SIZE*8-1:0] memWriteData,
    input  logic                    memBusy,
    input  logic [BLOCK_SIZE*8-1:0] memReadData
);

    localparam int DW = BLOCK_SIZE * 8;

    logic [1:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  cooldown_q, cooldown_d;
    logic                  cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DW-1:0]         resp_q, resp_d;

    logic i_req, d_req, i_elig, d_elig, win, active;

    assign i_req = iMemRead;
    assign d_req = dMemRead | dMemWrite;

    // The side just served may still hold its request for one cycle after DONE.
    assign i_elig = i_req && !(cooldown_q && last_grant_q == GRANT_I);
    assign d_elig = d_req && !(cooldown_q && last_grant_q == GRANT_D);
    assign win    = pick_grant(i_elig, d_elig, last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cooldown_d   = cooldown_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_d       = resp_q;
        case (state_q)
            ST_IDLE: begin
                cooldown_d = 1'b0;
                if (i_elig || d_elig) begin
                    grant_d = win;
                    state_d = ST_ISSUE;
                    if (win == GRANT_D) begin
                        cmd_d   = dMemWrite ? CMD_WRITE : CMD_READ;
                        addr_d  = dMemAddress;
                        wdata_d = dMemWriteData;
                    end else begin
                        cmd_d   = CMD_READ;
                        addr_d  = iMemAddress;
                        wdata_d = '0;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!memBusy) begin
                    resp_d  = memReadData;
                    state_d = ST_DONE;
                end
            end
            default: begin
                last_grant_d = grant_q;
                cooldown_d   = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            cooldown_q   <= 1'b0;
            cmd_q        <= CMD_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cooldown_q   <= cooldown_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_q       <= resp_d;
        end
    end

    assign active       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign memRead      = active && (cmd_q == CMD_READ);
    assign memWrite     = active && (cmd_q == CMD_WRITE);
    assign memAddress   = active ? addr_q  : '0;
    assign memWriteData = active ? wdata_q : '0;

    // Busy drops only in the granted side's DONE cycle.
    assign iMemBusy     = i_req && !(state_q == ST_DONE && grant_q == GRANT_I);
    assign dMemBusy     = d_req && !(state_q == ST_DONE && grant_q == GRANT_D);
    assign iMemReadData = resp_q;
    assign dMemReadData = resp_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed I/D traffic against a
// latency-programmable memory model; monitors pop expected commands/responses.
module tb_cache_mem_arbiter;

    localparam int DW = 256;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          iMemRead, dMemRead, dMemWrite;
    logic [31:0]   iMemAddress, dMemAddress, memAddress;
    logic [DW-1:0] dMemWriteData, iMemReadData, dMemReadData, memWriteData, memReadData;
    logic          iMemBusy, dMemBusy, memRead, memWrite, memBusy;

    cache_mem_arbiter #(.BLOCK_SIZE(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .iMemRead(iMemRead), .iMemAddress(iMemAddress), .iMemBusy(iMemBusy),
        .iMemReadData(iMemReadData),
        .dMemRead(dMemRead), .dMemWrite(dMemWrite), .dMemAddress(dMemAddress),
        .dMemWriteData(dMemWriteData), .dMemBusy(dMemBusy), .dMemReadData(dMemReadData),
        .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
        .memWriteData(memWriteData), .memBusy(memBusy), .memReadData(memReadData)
    );

    always #5 clk = ~clk;

    // Memory model: busy for 'lat' cycles starting with the ISSUE cycle.
    int lat = 2;
    int mcnt = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !(memRead || memWrite)) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end
    assign memBusy     = (memRead || memWrite) && (mcnt < lat);
    assign memReadData = memWrite ? '0 : {8{memAddress ^ 32'hDEAD_0000}};

    cmd_t          cmd_q[$];
    logic [DW-1:0] iresp_q[$], dresp_q[$];
    int            cmd_cyc[$];
    int n_vec = 0, n_err = 0;
    int cnt_mrd = 0, cnt_mwr = 0, cnt_ilow = 0, cnt_dlow = 0, cnt_dhigh = 0, cnt_cmd = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [DW-1:0] wd);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wd;
        cmd_q.push_back(c);
    endtask

    task automatic clr_cnt();
        cnt_mrd = 0; cnt_mwr = 0; cnt_ilow = 0; cnt_dlow = 0; cnt_dhigh = 0; cnt_cmd = 0;
        cmd_cyc.delete();
    endtask

    // Command monitor: a new command is one seen while the model's counter is 0.
    always @(negedge clk) begin : cmd_mon
        cmd_t e;
        if (!rst && (memRead || memWrite) && mcnt == 0) begin
            cnt_cmd++;
            cmd_cyc.push_back(cyc);
            if (cmd_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL cmd_unexpected: got wr=%0b addr=%h want none", memWrite, memAddress);
            end else begin
                e = cmd_q.pop_front();
                chk("cmd_write", {255'd0, memWrite}, {255'd0, e.wr});
                chk("cmd_read",  {255'd0, memRead},  {255'd0, !e.wr});
                chk("cmd_addr",  {224'd0, memAddress}, {224'd0, e.addr});
                chk("cmd_wdata", memWriteData, e.wr ? e.wdata : '0);
            end
        end
    end

    // Response monitor: completion is a requester whose busy has dropped.
    always @(negedge clk) begin : resp_mon
        if (memRead) cnt_mrd++;
        if (memWrite) cnt_mwr++;
        if (dMemBusy) cnt_dhigh++;
        if (iMemRead && !iMemBusy) begin
            cnt_ilow++;
            if (iresp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL i_resp_unexpected: got %h want none", iMemReadData);
            end else chk("i_resp", iMemReadData, iresp_q.pop_front());
        end
        if ((dMemRead || dMemWrite) && !dMemBusy) begin
            cnt_dlow++;
            if (dresp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d_resp_unexpected: got %h want none", dMemReadData);
            end else chk("d_resp", dMemReadData, dresp_q.pop_front());
        end
    end

    // Requester: n line transactions at base, base+32, ...; request stays high
    // between jobs and is dropped 'extra' cycles after the last completion.
    task automatic req_seq(input bit side_d, input bit wr, input logic [31:0] base,
                           input logic [DW-1:0] wd, input int n, input int extra);
        int k;
        @(posedge clk); #1;
        for (int j = 0; j < n; j++) begin
            if (side_d) begin
                dMemRead = !wr; dMemWrite = wr;
                dMemAddress = base + 32'(j * 32); dMemWriteData = wd;
            end else begin
                iMemRead = 1'b1; iMemAddress = base + 32'(j * 32);
            end
            for (k = 0; k < 300; k++) begin
                @(negedge clk);
                if (!(side_d ? dMemBusy : iMemBusy)) break;
            end
            if (k == 300) begin
                n_vec++; n_err++;
                $display("FAIL req_timeout: got busy after 300 cycles want done (side_d=%0b)", side_d);
            end
            if (j == n - 1) repeat (extra) @(posedge clk);
            @(posedge clk); #1;
        end
        if (side_d) begin dMemRead = 1'b0; dMemWrite = 1'b0; end
        else iMemRead = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        iMemRead = 0; iMemAddress = 0;
        dMemRead = 0; dMemWrite = 0; dMemAddress = 0; dMemWriteData = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_memRead",  {255'd0, memRead},  '0);
        chk("rst_memWrite", {255'd0, memWrite}, '0);
        chk("rst_memAddr",  {224'd0, memAddress}, '0);
        chk("rst_iBusy",    {255'd0, iMemBusy}, '0);
        chk("rst_dBusy",    {255'd0, dMemBusy}, '0);
        chk("rst_iData",    iMemReadData, '0);
        chk("rst_dData",    dMemReadData, '0);

        // I-only read, memory busy 4 cycles
        @(posedge clk); #1;
        lat = 4; clr_cnt();
        push_cmd(1'b0, 32'h0000_1040, '0);
        iresp_q.push_back({8{32'hDEAD_1040}});
        req_seq(1'b0, 1'b0, 32'h0000_1040, '0, 1, 0);
        repeat (3) @(posedge clk); #1;
        chk("t1_memRead_cycles", DW'(cnt_mrd), DW'(5));
        chk("t1_iBusy_low_cycles", DW'(cnt_ilow), DW'(1));
        chk("t1_dBusy_high_cycles", DW'(cnt_dhigh), DW'(0));
        chk("t1_memWrite_cycles", DW'(cnt_mwr), DW'(0));

        // Simultaneous I and D reads: D first, I follows after one cooldown IDLE
        lat = 2; clr_cnt();
        push_cmd(1'b0, 32'h0000_4000, '0);
        push_cmd(1'b0, 32'h0000_3000, '0);
        dresp_q.push_back({8{32'hDEAD_4000}});
        iresp_q.push_back({8{32'hDEAD_3000}});
        fork
            req_seq(1'b1, 1'b0, 32'h0000_4000, '0, 1, 0);
            req_seq(1'b0, 1'b0, 32'h0000_3000, '0, 1, 0);
        join
        repeat (3) @(posedge clk); #1;
        chk("t2_cmd_count", DW'(cnt_cmd), DW'(2));
        if (cmd_cyc.size() == 2) chk("t2_issue_gap", DW'(cmd_cyc[1] - cmd_cyc[0]), DW'(5));

        // D write-back
        lat = 3; clr_cnt();
        push_cmd(1'b1, 32'h0000_2000, {8{32'hB00B_2000}});
        dresp_q.push_back('0);
        req_seq(1'b1, 1'b1, 32'h0000_2000, {8{32'hB00B_2000}}, 1, 0);
        repeat (3) @(posedge clk); #1;
        chk("t3_memWrite_cycles", DW'(cnt_mwr), DW'(4));
        chk("t3_memRead_cycles", DW'(cnt_mrd), DW'(0));
        chk("t3_dBusy_low_cycles", DW'(cnt_dlow), DW'(1));

        // D holds one cycle past DONE while I waits: I next, no duplicate D
        lat = 2; clr_cnt();
        push_cmd(1'b0, 32'h0000_5000, '0);
        push_cmd(1'b0, 32'h0000_6000, '0);
        dresp_q.push_back({8{32'hDEAD_5000}});
        iresp_q.push_back({8{32'hDEAD_6000}});
        fork
            req_seq(1'b1, 1'b0, 32'h0000_5000, '0, 1, 1);
            begin @(posedge clk); req_seq(1'b0, 1'b0, 32'h0000_6000, '0, 1, 0); end
        join
        repeat (4) @(posedge clk); #1;
        chk("t4_cmd_count", DW'(cnt_cmd), DW'(2));

        // Continuous traffic from both sides: D, I, D, I, ...
        lat = 1; clr_cnt();
        for (int j = 0; j < 5; j++) begin
            push_cmd(1'b0, 32'h0000_7000 + 32'(j * 32), '0);
            push_cmd(1'b0, 32'h0000_8000 + 32'(j * 32), '0);
            dresp_q.push_back({8{32'hDEAD_7000 + 32'(j * 32)}});
            iresp_q.push_back({8{32'hDEAD_8000 + 32'(j * 32)}});
        end
        fork
            req_seq(1'b1, 1'b0, 32'h0000_7000, '0, 5, 0);
            req_seq(1'b0, 1'b0, 32'h0000_8000, '0, 5, 0);
        join
        repeat (3) @(posedge clk); #1;
        chk("t5_cmd_count", DW'(cnt_cmd), DW'(10));

        // Reset in the middle of WAIT; the held I request is re-issued
        lat = 6; clr_cnt();
        push_cmd(1'b0, 32'h0000_9000, '0);
        push_cmd(1'b0, 32'h0000_9000, '0);
        iresp_q.push_back({8{32'hDEAD_9000}});
        fork
            req_seq(1'b0, 1'b0, 32'h0000_9000, '0, 1, 0);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (memRead) break;
                end
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("t6_rst_memRead", {255'd0, memRead}, '0);
                chk("t6_rst_memAddr", {224'd0, memAddress}, '0);
                chk("t6_rst_iBusy", {255'd0, iMemBusy}, {255'd0, 1'b1});
                chk("t6_rst_dBusy", {255'd0, dMemBusy}, '0);
            end
        join
        repeat (3) @(posedge clk); #1;
        chk("t6_cmd_count", DW'(cnt_cmd), DW'(2));

        repeat (3) @(posedge clk); #1;
        chk("end_cmd_queue", DW'(cmd_q.size()), '0);
        chk("end_iresp_queue", DW'(iresp_q.size()), '0);
        chk("end_dresp_queue", DW'(dresp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
